// File: rtl/calc_pkg.sv
// calc_pkg: opcodes, legality check and FSM states shared by the calc_arbiter slice
package calc_pkg;
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MUL5  = 4'b0010;
  localparam logic [3:0] OP_DIV10 = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_NOT   = 4'b0111;
  localparam logic [3:0] OP_INC   = 4'b1000;
  localparam logic [3:0] OP_DEC   = 4'b1001;
  localparam logic [3:0] OP_LAST  = OP_DEC;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_LAST;
  endfunction
endpackage

// File: rtl/calc_arbiter_if.sv
// calc_arbiter_if: two-requester request channels, tagged response channel and overflow status
interface calc_arbiter_if #(parameter int CNT_W = 8);
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req0_op;
  logic [3:0] req1_op;
  logic signed [15:0] req0_a;
  logic signed [15:0] req1_a;
  logic signed [15:0] req0_b;
  logic signed [15:0] req1_b;
  logic rsp_valid;
  logic rsp_ready;
  logic rsp_id;
  logic signed [15:0] rsp_result;
  logic rsp_ovf;
  logic rsp_err;
  logic [CNT_W-1:0] ovf_cnt0;
  logic [CNT_W-1:0] ovf_cnt1;
  logic cnt_clr;
  modport master (
    output req_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b, rsp_ready, cnt_clr,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_ovf, rsp_err, ovf_cnt0, ovf_cnt1
  );
  modport slave (
    input  req_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b, rsp_ready, cnt_clr,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_ovf, rsp_err, ovf_cnt0, ovf_cnt1
  );
endinterface

// File: rtl/calculator.sv
// calculator: combinational 16-bit signed ALU, overflow doubles as the inexact flag for div-by-10
module calculator import calc_pkg::*; (
  input  logic [3:0]         op,
  input  logic signed [15:0] in1,
  input  logic signed [15:0] in2,
  output logic signed [15:0] result,
  output logic               overflow
);
  logic [16:0] add_w, sub_w, inc_w, dec_w;
  logic [18:0] mul_w;
  logic signed [15:0] quo, rem;
  assign add_w = {in1[15], in1} + {in2[15], in2};
  assign sub_w = {in1[15], in1} - {in2[15], in2};
  assign inc_w = {in1[15], in1} + 17'd1;
  assign dec_w = {in1[15], in1} - 17'd1;
  assign mul_w = {{3{in1[15]}}, in1} * 19'd5;
  assign quo = in1 / 16'sd10;
  assign rem = in1 % 16'sd10;
  always_comb begin
    result = '0;
    overflow = 1'b0;
    case (op)
      OP_ADD:   begin result = add_w[15:0]; overflow = add_w[16] ^ add_w[15]; end
      OP_SUB:   begin result = sub_w[15:0]; overflow = sub_w[16] ^ sub_w[15]; end
      OP_MUL5:  begin result = mul_w[15:0]; overflow = mul_w[18:15] != {4{mul_w[15]}}; end
      OP_DIV10: begin result = quo; overflow = rem != 16'sd0; end
      OP_AND:   result = in1 & in2;
      OP_XOR:   result = in1 ^ in2;
      OP_OR:    result = in1 | in2;
      OP_NOT:   result = ~in1;
      OP_INC:   begin result = inc_w[15:0]; overflow = inc_w[16] ^ inc_w[15]; end
      OP_DEC:   begin result = dec_w[15:0]; overflow = dec_w[16] ^ dec_w[15]; end
      default:  ;
    endcase
  end
endmodule

// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin sharing of one calculator between two requesters with tagged, backpressured responses
module calc_arbiter import calc_pkg::*; #(
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  calc_arbiter_if.slave bus
);
  state_t state, nxt;
  logic accept, g, last_grant, id_q, legal, bump, calc_ovf;
  logic [3:0] op_q;
  logic signed [15:0] a_q, b_q, calc_res;
  logic [CNT_W-1:0] cnt0, cnt1;
  calculator u_calc (
    .op(op_q),
    .in1(a_q),
    .in2(b_q),
    .result(calc_res),
    .overflow(calc_ovf)
  );
  assign accept = state == IDLE && |bus.req_valid;
  assign g = &bus.req_valid ? ~last_grant : bus.req_valid[1];
  assign legal = op_legal(op_q);
  assign bump = state == EXEC && legal && calc_ovf;
  assign bus.rsp_valid = state == RESP;
  assign bus.ovf_cnt0 = cnt0;
  assign bus.ovf_cnt1 = cnt1;
  always_comb begin
    nxt = state;
    bus.req_ready = 2'b00;
    case (state)
      IDLE: begin
        nxt = accept ? EXEC : IDLE;
        bus.req_ready = accept ? (g ? 2'b10 : 2'b01) : 2'b00;
      end
      EXEC: nxt = RESP;
      RESP: nxt = bus.rsp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      id_q <= 1'b0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      bus.rsp_id <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_ovf <= 1'b0;
      bus.rsp_err <= 1'b0;
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        last_grant <= g;
        id_q <= g;
        op_q <= g ? bus.req1_op : bus.req0_op;
        a_q <= g ? bus.req1_a : bus.req0_a;
        b_q <= g ? bus.req1_b : bus.req0_b;
      end
      if (state == EXEC) begin
        bus.rsp_id <= id_q;
        bus.rsp_result <= legal ? calc_res : '0;
        bus.rsp_ovf <= legal && calc_ovf;
        bus.rsp_err <= !legal;
      end
      if (bus.cnt_clr) begin
        cnt0 <= '0;
        cnt1 <= '0;
      end else if (bump) begin
        if (!id_q && ~&cnt0) cnt0 <= cnt0 + CNT_W'(1);
        if (id_q && ~&cnt1) cnt1 <= cnt1 + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: scoreboard bench for arbitration, latency, overflow counting, backpressure and reset
module tb_calc_arbiter;
  import calc_pkg::*;
  typedef struct packed {
    logic id;
    logic [15:0] res;
    logic ovf;
    logic err;
  } exp_t;
  logic clk, rst;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  exp_t mon_e;
  exp_t mon_g;
  calc_arbiter_if #(.CNT_W(8)) bus();
  calc_arbiter #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic exp_t model(input logic id, input logic [3:0] op, input logic signed [15:0] a, input logic signed [15:0] b);
    exp_t e;
    int r;
    e = '0;
    e.id = id;
    r = 0;
    case (op)
      4'd0: r = int'(a) + int'(b);
      4'd1: r = int'(a) - int'(b);
      4'd2: r = int'(a) * 5;
      4'd3: begin r = int'(a) / 10; e.ovf = (int'(a) % 10) != 0; end
      4'd4: r = int'(a & b);
      4'd5: r = int'(a ^ b);
      4'd6: r = int'(a | b);
      4'd7: r = int'(~a);
      4'd8: r = int'(a) + 1;
      4'd9: r = int'(a) - 1;
      default: e.err = 1'b1;
    endcase
    if (op inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9}) e.ovf = r > 32767 || r < -32768;
    if (!e.err) e.res = r[15:0];
    return e;
  endfunction
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      mon_g = {bus.rsp_id, bus.rsp_result, bus.rsp_ovf, bus.rsp_err};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected got id=%0d res=%0d ovf=%0d err=%0d expected no response", mon_g.id, $signed(mon_g.res), mon_g.ovf, mon_g.err);
      end else begin
        mon_e = sb.pop_front();
        if (mon_g !== mon_e) begin
          bad++;
          $display("FAIL rsp id/res/ovf/err got=%0d/%0d/%0d/%0d expected=%0d/%0d/%0d/%0d",
                   mon_g.id, $signed(mon_g.res), mon_g.ovf, mon_g.err, mon_e.id, $signed(mon_e.res), mon_e.ovf, mon_e.err);
        end
      end
    end
  end
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic issue(input logic id, input logic [3:0] op, input logic signed [15:0] a, input logic signed [15:0] b, output logic [1:0] seen);
    int n;
    if (id) begin
      bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
    bus.req_valid[id] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      seen = bus.req_ready;
      n++;
    end while (!seen[id] && n < 50);
    total++;
    if (!seen[id]) begin
      bad++;
      $display("FAIL accept_timeout id=%0d got req_ready=%b expected bit %0d high", id, seen, id);
    end else sb.push_back(model(id, op, a, b));
    @(posedge clk);
    #1 bus.req_valid[id] = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got %0d pending responses expected 0", sb.size());
      sb.delete();
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b expected=00", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b expected=0", bus.rsp_valid); end
    total++; if (bus.rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp_id got=%b expected=0", bus.rsp_id); end
    total++; if (bus.rsp_result !== 16'sd0) begin bad++; $display("FAIL reset_rsp_result got=%0d expected=0", bus.rsp_result); end
    total++; if ({bus.rsp_ovf, bus.rsp_err} !== 2'b00) begin bad++; $display("FAIL reset_ovf_err got=%b expected=00", {bus.rsp_ovf, bus.rsp_err}); end
    total++; if (bus.ovf_cnt0 !== 8'd0 || bus.ovf_cnt1 !== 8'd0) begin bad++; $display("FAIL reset_counters got=%0d/%0d expected=0/0", bus.ovf_cnt0, bus.ovf_cnt1); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_single();
    logic [1:0] seen;
    bus.rsp_ready = 1'b1;
    issue(1'b0, OP_ADD, 16'sd100, -16'sd30, seen);
    total++; if (seen !== 2'b01) begin bad++; $display("FAIL single_grant got=%b expected=01", seen); end
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b expected=0", bus.rsp_valid); end
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL single_latency got=%b expected=1", bus.rsp_valid); end
    total++; if (bus.rsp_id !== 1'b0 || bus.rsp_result !== 16'sd70 || bus.rsp_ovf !== 1'b0) begin
      bad++; $display("FAIL single_rsp got id=%0d res=%0d ovf=%0d expected id=0 res=70 ovf=0", bus.rsp_id, bus.rsp_result, bus.rsp_ovf);
    end
    drain();
  endtask
  task automatic test_round_robin();
    int n;
    logic [1:0] want;
    do_reset();
    bus.req0_op = OP_INC; bus.req0_a = 16'sd5; bus.req0_b = 16'sd0;
    bus.req1_op = OP_INC; bus.req1_a = 16'sd5; bus.req1_b = 16'sd0;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      want = (k % 2) ? 2'b10 : 2'b01;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.req_ready == 2'b00 && n < 50);
      total++;
      if (bus.req_ready !== want) begin bad++; $display("FAIL rr_grant%0d got=%b expected=%b", k, bus.req_ready, want); end
      sb.push_back(model(want[1], OP_INC, 16'sd5, 16'sd0));
      @(posedge clk);
    end
    #1 bus.req_valid = 2'b00;
    drain();
  endtask
  task automatic test_overflow();
    logic [1:0] seen;
    do_reset();
    issue(1'b1, OP_ADD, 16'sd32767, 16'sd1, seen);
    drain();
    total++; if (bus.ovf_cnt1 !== 8'd1) begin bad++; $display("FAIL ovf_cnt1_first got=%0d expected=1", bus.ovf_cnt1); end
    for (int k = 0; k < 299; k++) begin
      issue(1'b1, OP_ADD, 16'sd32767, 16'sd1, seen);
      drain();
    end
    total++; if (bus.ovf_cnt1 !== 8'd255) begin bad++; $display("FAIL ovf_cnt1_saturate got=%0d expected=255", bus.ovf_cnt1); end
    total++; if (bus.ovf_cnt0 !== 8'd0) begin bad++; $display("FAIL ovf_cnt0_untouched got=%0d expected=0", bus.ovf_cnt0); end
  endtask
  task automatic test_div_err();
    logic [1:0] seen;
    issue(1'b0, OP_DIV10, 16'sd25, 16'sd0, seen);
    drain();
    total++; if (bus.ovf_cnt0 !== 8'd1) begin bad++; $display("FAIL div_inexact_cnt got=%0d expected=1", bus.ovf_cnt0); end
    issue(1'b0, 4'b1100, 16'sd7, 16'sd9, seen);
    drain();
    total++; if (bus.ovf_cnt0 !== 8'd1 || bus.ovf_cnt1 !== 8'd255) begin
      bad++; $display("FAIL illegal_cnt got=%0d/%0d expected=1/255", bus.ovf_cnt0, bus.ovf_cnt1);
    end
  endtask
  task automatic test_backpressure();
    logic [1:0] seen;
    int n;
    bus.rsp_ready = 1'b0;
    issue(1'b0, OP_XOR, 16'sh00ff, 16'sh0f0f, seen);
    bus.req1_op = OP_AND; bus.req1_a = 16'sh1234; bus.req1_b = 16'sh00ff;
    bus.req_valid[1] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_ovf, bus.rsp_err, bus.req_ready} !== {1'b1, 1'b0, 16'h0ff0, 1'b0, 1'b0, 2'b00}) begin
        bad++; $display("FAIL bp_hold%0d got valid=%b id=%b res=%h ready=%b expected valid=1 id=0 res=0ff0 ready=00",
                        k, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.req_ready);
      end
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.req_ready == 2'b00 && n < 50);
    total++;
    if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL bp_next_grant got=%b expected=10", bus.req_ready); end
    sb.push_back(model(1'b1, OP_AND, 16'sh1234, 16'sh00ff));
    @(posedge clk);
    #1 bus.req_valid[1] = 1'b0;
    drain();
  endtask
  task automatic test_rst_exec();
    logic [1:0] seen;
    logic saw;
    bus.rsp_ready = 1'b1;
    issue(1'b0, OP_ADD, 16'sd32767, 16'sd1, seen);
    void'(sb.pop_back());
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_ovf, bus.rsp_err} !== 22'd0) begin
      bad++; $display("FAIL rst_exec_outputs got ready=%b valid=%b id=%b res=%0d ovf=%b err=%b expected all 0",
                      bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_ovf, bus.rsp_err);
    end
    total++; if (bus.ovf_cnt0 !== 8'd0 || bus.ovf_cnt1 !== 8'd0) begin bad++; $display("FAIL rst_exec_counters got=%0d/%0d expected=0/0", bus.ovf_cnt0, bus.ovf_cnt1); end
    saw = 1'b0;
    repeat (4) begin @(negedge clk); saw |= bus.rsp_valid; end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL rst_exec_no_rsp got=%b expected=0", saw); end
    @(posedge clk);
    #1;
    issue(1'b1, OP_ADD, 16'sd32767, 16'sd1, seen);
    drain();
    total++; if (bus.ovf_cnt1 !== 8'd1) begin bad++; $display("FAIL clr_pre got=%0d expected=1", bus.ovf_cnt1); end
    issue(1'b1, OP_ADD, 16'sd32767, 16'sd1, seen);
    bus.cnt_clr = 1'b1;
    @(posedge clk);
    #1 bus.cnt_clr = 1'b0;
    drain();
    total++; if (bus.ovf_cnt1 !== 8'd0) begin bad++; $display("FAIL clr_priority got=%0d expected=0", bus.ovf_cnt1); end
  endtask
  initial begin
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready = 1'b1;
    bus.cnt_clr = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_div_err();
    test_backpressure();
    test_rst_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
